// File: rtl/bpm_pkg.sv
// Shared definitions for the BPM acquisition chain: capture FSM states,
// default word width and header word layout.
package bpm_pkg;

  localparam int DATA_W_DEFAULT = 16;
  localparam int HDR_EVT_LSB    = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_HEADER,
    S_CAPTURE,
    S_DONE
  } state_t;

endpackage

// File: rtl/bpm_event_capture_if.sv
// Control, trigger, ADC and capture-FIFO write signals of the event capture block.
// The slave modport is the capture block itself; master is whoever drives it.
interface bpm_event_capture_if
  import bpm_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int NSAMP_W = 12
);

  logic               arm;
  logic               trig_in;
  logic [NSAMP_W-1:0] trig_delay;
  logic [NSAMP_W-1:0] nsamp;
  logic [DATA_W-1:0]  adc_data;
  logic               fifo_full;
  logic               fifo_wr_en;
  logic [DATA_W-1:0]  fifo_din;
  logic               busy;
  logic               done;
  logic               overflow;
  logic [15:0]        evt_cnt;
  logic [7:0]         miss_cnt;

  modport master (
    output arm, trig_in, trig_delay, nsamp, adc_data, fifo_full,
    input  fifo_wr_en, fifo_din, busy, done, overflow, evt_cnt, miss_cnt
  );

  modport slave (
    input  arm, trig_in, trig_delay, nsamp, adc_data, fifo_full,
    output fifo_wr_en, fifo_din, busy, done, overflow, evt_cnt, miss_cnt
  );

endinterface

// File: rtl/trig_sync_edge.sv
// N-flop synchroniser for an asynchronous level input, followed by a
// registered rising-edge detector producing a single-cycle pulse.
module trig_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              r_rise;

  // Shift in from the LSB; the cast keeps the lowest STAGES bits so STAGES=1 also works.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= STAGES'({r_sync, i_async});
      r_prev <= r_sync[STAGES-1];
      r_rise <= r_sync[STAGES-1] & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/bpm_event_capture.sv
// Trigger-driven event framer: writes a header word with the event counter
// followed by a runtime-selected number of ADC samples into the capture FIFO.
module bpm_event_capture
  import bpm_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int NSAMP_W     = 12,
  parameter int SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                rst,
  bpm_event_capture_if.slave bus
);

  state_t             r_state, w_next;
  logic [NSAMP_W-1:0] r_dcnt, w_dcnt;
  logic [NSAMP_W-1:0] r_scnt, w_scnt;
  logic [DATA_W-1:0]  r_adc;
  logic [DATA_W-1:0]  r_din;
  logic               r_wr, r_busy, r_done, r_ovf;
  logic [15:0]        r_evt;
  logic [7:0]         r_miss;
  logic               w_rise, w_miss, w_write;
  logic [DATA_W-1:0]  w_hdr;

  trig_sync_edge #(.STAGES(SYNC_STAGES)) u_trig (
    .clk     (clk),
    .rst     (rst),
    .i_async (bus.trig_in),
    .o_rise  (w_rise)
  );

  assign w_hdr = DATA_W'({16'd0, r_evt} << HDR_EVT_LSB);

  // Arm beats a coincident trigger in IDLE/DONE, so that trigger is neither captured nor missed.
  always_comb begin
    w_next = r_state;
    w_dcnt = r_dcnt;
    w_scnt = r_scnt;
    w_miss = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.arm) w_next = S_ARMED;
        else if (w_rise) w_miss = 1'b1;
      end
      S_ARMED: begin
        if (w_rise) begin
          w_dcnt = bus.trig_delay;
          w_scnt = (bus.nsamp == '0) ? NSAMP_W'(1) : bus.nsamp;
          w_next = (bus.trig_delay == '0) ? S_HEADER : S_DELAY;
        end
      end
      S_DELAY: begin
        if (r_dcnt == NSAMP_W'(1)) w_next = S_HEADER;
        else w_dcnt = r_dcnt - NSAMP_W'(1);
      end
      S_HEADER: w_next = S_CAPTURE;
      S_CAPTURE: begin
        if (r_scnt == NSAMP_W'(1)) w_next = S_DONE;
        else w_scnt = r_scnt - NSAMP_W'(1);
      end
      S_DONE: begin
        if (bus.arm) w_next = S_ARMED;
        else if (w_rise) w_miss = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
    w_write = (w_next == S_HEADER) || (w_next == S_CAPTURE);
  end

  // Outputs are registered from the next state, so a write slot is dropped
  // when fifo_full is seen on the edge that would launch it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_dcnt  <= '0;
      r_scnt  <= '0;
      r_adc   <= '0;
      r_din   <= '0;
      r_wr    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_evt   <= '0;
      r_miss  <= '0;
    end else begin
      r_state <= w_next;
      r_dcnt  <= w_dcnt;
      r_scnt  <= w_scnt;
      r_adc   <= bus.adc_data;
      r_wr    <= w_write & ~bus.fifo_full;
      if (w_write) r_din <= (w_next == S_HEADER) ? w_hdr : r_adc;
      if (w_write && bus.fifo_full) r_ovf <= 1'b1;
      r_busy  <= (w_next inside {S_ARMED, S_DELAY, S_HEADER, S_CAPTURE});
      r_done  <= (w_next == S_DONE);
      if (w_next == S_DONE && r_state != S_DONE) r_evt <= r_evt + 16'd1;
      if (w_miss && r_miss != 8'hFF) r_miss <= r_miss + 8'd1;
    end
  end

  assign bus.fifo_wr_en = r_wr;
  assign bus.fifo_din   = r_din;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.overflow   = r_ovf;
  assign bus.evt_cnt    = r_evt;
  assign bus.miss_cnt   = r_miss;

endmodule

// File: tb/tb_bpm_event_capture.sv
// Self-checking bench for bpm_event_capture: randomized ADC data and frame
// parameters against a cycle-indexed model of the expected frame contents.
module tb_bpm_event_capture;
  import bpm_pkg::*;

  localparam int DATA_W  = 16;
  localparam int NSAMP_W = 12;
  localparam int SYNC    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bpm_event_capture_if #(.DATA_W(DATA_W), .NSAMP_W(NSAMP_W)) bus ();

  bpm_event_capture #(.DATA_W(DATA_W), .NSAMP_W(NSAMP_W), .SYNC_STAGES(SYNC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [DATA_W-1:0] adcHist [int];
  bit                fullHist [int];
  int                wrC [$];
  logic [DATA_W-1:0] wrD [$];
  int                doneCyc;
  bit                rampMode;
  logic [DATA_W-1:0] rampVal;
  int                mEvt, mMiss;
  bit                mOvf;

  // Inputs presented in cycle cyc are logged, then outputs after the next edge are observed.
  task automatic step();
    adcHist[cyc]  = bus.adc_data;
    fullHist[cyc] = bus.fifo_full;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.fifo_wr_en === 1'b1) begin
      wrC.push_back(cyc);
      wrD.push_back(bus.fifo_din);
    end
    if (bus.done === 1'b1 && doneCyc < 0) doneCyc = cyc;
    if (rampMode) begin
      rampVal++;
      bus.adc_data = rampVal;
    end else begin
      bus.adc_data = DATA_W'($urandom);
    end
  endtask

  task automatic clearLog();
    wrC.delete();
    wrD.delete();
    doneCyc = -1;
  endtask

  task automatic doReset();
    bus.arm = 1'b0; bus.trig_in = 1'b0; bus.fifo_full = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    mEvt = 0; mMiss = 0; mOvf = 1'b0;
  endtask

  task automatic applyArm();
    bus.arm = 1'b1;
    step();
    bus.arm = 1'b0;
  endtask

  // Starts from ARMED with trig_in low and settled. The rise appears SYNC+1 cycles
  // after trig_in goes high and is consumed on the edge closing that cycle; the header
  // follows d cycles later, each sample is the ADC word from two cycles before its write.
  task automatic runFrame(input int d, input int n, input int dropK, input int hold, input string tag);
    int t, n1, H, riseCyc;
    int expC [$];
    logic [DATA_W-1:0] expD [$];
    bus.trig_delay = NSAMP_W'(d);
    bus.nsamp      = NSAMP_W'(n);
    bus.trig_in    = 1'b1;
    t = cyc;
    clearLog();
    n1 = (n == 0) ? 1 : n;
    riseCyc = t + SYNC + 1;
    H = riseCyc + 1 + d;
    while (cyc < H + n1 + 3 || cyc < t + hold) begin
      bus.fifo_full = (dropK >= 0 && cyc == H + dropK - 1);
      step();
      if (cyc == H) begin
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
          errors++;
          $display("[TB] FAIL %s busy_in_header: got busy=%b done=%b want busy=1 done=0", tag, bus.busy, bus.done);
        end
      end
    end
    bus.fifo_full = 1'b0;
    bus.trig_in   = 1'b0;
    for (int k = 0; k <= n1; k++) begin
      if (fullHist[H + k - 1]) begin
        mOvf = 1'b1;
        continue;
      end
      expC.push_back(H + k);
      expD.push_back((k == 0) ? DATA_W'(mEvt & 32'hFFFF) : adcHist[H + k - 2]);
    end
    checks++;
    if (wrC.size() !== expC.size()) begin
      errors++;
      $display("[TB] FAIL %s write_count: got %0d want %0d", tag, wrC.size(), expC.size());
    end
    for (int i = 0; i < wrC.size() && i < expC.size(); i++) begin
      checks++;
      if (wrC[i] !== expC[i] || wrD[i] !== expD[i]) begin
        errors++;
        $display("[TB] FAIL %s write%0d: got cyc=%0d data=%h want cyc=%0d data=%h",
                 tag, i, wrC[i] - t, wrD[i], expC[i] - t, expD[i]);
      end
    end
    mEvt = (mEvt + 1) & 32'hFFFF;
    checks++;
    if (doneCyc !== H + n1 + 1) begin
      errors++;
      $display("[TB] FAIL %s done_cycle: got %0d want %0d", tag, doneCyc - t, H + n1 + 1 - t);
    end
    checks++;
    if (bus.evt_cnt !== 16'(mEvt) || bus.busy !== 1'b0 || bus.done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s end_state: got evt=%0d busy=%b done=%b want evt=%0d busy=0 done=1",
               tag, bus.evt_cnt, bus.busy, bus.done, mEvt);
    end
    checks++;
    if (bus.overflow !== mOvf || bus.miss_cnt !== 8'(mMiss)) begin
      errors++;
      $display("[TB] FAIL %s flags: got ovf=%b miss=%0d want ovf=%b miss=%0d",
               tag, bus.overflow, bus.miss_cnt, mOvf, mMiss);
    end
    repeat (5) step();
  endtask

  task automatic test_reset();
    bus.trig_delay = '0; bus.nsamp = '0; bus.adc_data = '0;
    doReset();
    checks++;
    if (bus.fifo_wr_en !== 1'b0 || bus.fifo_din !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.overflow !== 1'b0 || bus.evt_cnt !== 16'd0 || bus.miss_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got wr=%b din=%h busy=%b done=%b ovf=%b evt=%0d miss=%0d want all 0",
               bus.fifo_wr_en, bus.fifo_din, bus.busy, bus.done, bus.overflow, bus.evt_cnt, bus.miss_cnt);
    end
  endtask

  task automatic test_basic();
    doReset();
    rampMode = 1'b1;
    rampVal  = 16'h00FF;
    applyArm();
    rampVal = 16'h00FF;
    runFrame(0, 4, -1, 0, "basic");
    for (int i = 2; i < 5 && wrD.size() == 5; i++) begin
      checks++;
      if (wrD[i] !== wrD[i-1] + 16'd1) begin
        errors++;
        $display("[TB] FAIL basic_ramp%0d: got %h want %h", i, wrD[i], wrD[i-1] + 16'd1);
      end
    end
    rampMode = 1'b0;
  endtask

  task automatic test_delay();
    doReset();
    applyArm();
    runFrame(10, 3, -1, 0, "delay");
    clearLog();
    bus.trig_in = 1'b1;
    repeat (8) step();
    bus.trig_in = 1'b0;
    repeat (5) step();
    mMiss++;
    checks++;
    if (bus.miss_cnt !== 8'(mMiss) || wrC.size() != 0 || bus.done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL trig_in_done: got miss=%0d writes=%0d done=%b want miss=%0d writes=0 done=1",
               bus.miss_cnt, wrC.size(), bus.done, mMiss);
    end
  endtask

  task automatic test_rearm();
    applyArm();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rearm_done_drop: got done=%b busy=%b want done=0 busy=1", bus.done, bus.busy);
    end
    runFrame(2, 5, -1, 0, "rearm");
  endtask

  task automatic test_overflow();
    applyArm();
    runFrame(0, 4, 2, 0, "overflow");
    applyArm();
    runFrame(1, 2, -1, 0, "overflow_sticky");
  endtask

  task automatic test_reset_mid();
    applyArm();
    bus.trig_delay = '0;
    bus.nsamp      = NSAMP_W'(100);
    bus.trig_in    = 1'b1;
    repeat (25) step();
    clearLog();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.trig_in = 1'b0;
    mEvt = 0; mMiss = 0; mOvf = 1'b0;
    checks++;
    if (bus.fifo_wr_en !== 1'b0 || bus.fifo_din !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.overflow !== 1'b0 || bus.evt_cnt !== 16'd0 || bus.miss_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_outputs: got wr=%b din=%h busy=%b done=%b ovf=%b evt=%0d miss=%0d want all 0",
               bus.fifo_wr_en, bus.fifo_din, bus.busy, bus.done, bus.overflow, bus.evt_cnt, bus.miss_cnt);
    end
    repeat (10) step();
    checks++;
    if (wrC.size() != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_idle: got writes=%0d busy=%b want writes=0 busy=0", wrC.size(), bus.busy);
    end
  endtask

  task automatic test_nsamp0();
    applyArm();
    runFrame(0, 0, -1, 50, "nsamp0_hold");
  endtask

  task automatic test_miss_saturate();
    doReset();
    for (int i = 0; i < 260; i++) begin
      bus.trig_in = 1'b1;
      repeat (4) step();
      bus.trig_in = 1'b0;
      repeat (4) step();
      mMiss = (mMiss < 255) ? mMiss + 1 : 255;
      if (i == 99 || i == 259) begin
        checks++;
        if (bus.miss_cnt !== 8'(mMiss)) begin
          errors++;
          $display("[TB] FAIL miss_count_%0d: got %0d want %0d", i + 1, bus.miss_cnt, mMiss);
        end
      end
    end
  endtask

  task automatic test_arm_trig_collide();
    int t;
    doReset();
    clearLog();
    bus.trig_in = 1'b1;
    t = cyc;
    while (cyc < t + SYNC + 1) step();
    applyArm();
    repeat (10) step();
    bus.trig_in = 1'b0;
    repeat (5) step();
    checks++;
    if (bus.miss_cnt !== 8'd0 || bus.busy !== 1'b1 || wrC.size() != 0) begin
      errors++;
      $display("[TB] FAIL arm_trig_collide: got miss=%0d busy=%b writes=%0d want miss=0 busy=1 writes=0",
               bus.miss_cnt, bus.busy, wrC.size());
    end
  endtask

  task automatic test_random();
    int d, n, n1, drop;
    for (int f = 0; f < 8; f++) begin
      d    = $urandom_range(0, 12);
      n    = $urandom_range(0, 9);
      n1   = (n == 0) ? 1 : n;
      drop = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n1) : -1;
      runFrame(d, n, drop, 0, $sformatf("random%0d", f));
      if ($urandom_range(0, 1) == 1) begin
        bus.trig_in = 1'b1;
        repeat (5) step();
        bus.trig_in = 1'b0;
        repeat (5) step();
        mMiss++;
      end
      applyArm();
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.arm = 1'b0; bus.trig_in = 1'b0; bus.fifo_full = 1'b0;
    bus.trig_delay = '0; bus.nsamp = '0; bus.adc_data = '0;
    rampMode = 1'b0; rampVal = '0; doneCyc = -1;
    test_reset();
    test_basic();
    test_delay();
    test_rearm();
    test_overflow();
    test_reset_mid();
    test_nsamp0();
    test_miss_saturate();
    test_arm_trig_collide();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
